// File: rtl/synth_pkg.sv
// Shared synth types and constants.
// Holds the envelope state encoding and the default envelope width/full-scale level used
// by envelope_generator and env_sat_step.
package synth_pkg;

  localparam int unsigned ENV_W = 16;
  localparam logic [ENV_W-1:0] ENV_MAX = {ENV_W{1'b1}};

  // Encoding is visible on env_state (debug/LED), so the values are fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } env_state_t;

endpackage

// File: rtl/env_sat_step.sv
// Saturating envelope step (combinational).
// Moves env_i by rate_i towards limit_i (up: limit is a ceiling, down: a floor) and clamps
// to the limit. All arithmetic is carried out in W+1 bits so nothing wraps.
//   env_i   - current level
//   rate_i  - step size; 0 means jump straight to the limit
//   limit_i - ceiling (up_i=1) or floor (up_i=0)
//   up_i    - direction
//   env_o   - next level
//   hit_o   - limit reached on this step (phase complete)
module env_sat_step #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] env_i,
  input  logic [W-1:0] rate_i,
  input  logic [W-1:0] limit_i,
  input  logic         up_i,
  output logic [W-1:0] env_o,
  output logic         hit_o
);

  logic [W:0] sum;
  logic [W:0] floor_plus_rate;
  logic [W:0] env_ext;
  logic       rate_zero;

  assign env_ext         = {1'b0, env_i};
  assign sum             = env_ext + {1'b0, rate_i};
  assign floor_plus_rate = {1'b0, limit_i} + {1'b0, rate_i};
  assign rate_zero       = (rate_i == '0);

  always_comb begin
    hit_o = 1'b0;
    env_o = env_i;
    if (up_i) begin
      hit_o = rate_zero || (sum >= {1'b0, limit_i});
      env_o = hit_o ? limit_i : sum[W-1:0];
    end else begin
      // Compare against floor+rate instead of env-rate to avoid underflow.
      hit_o = rate_zero || (env_ext <= floor_plus_rate);
      env_o = hit_o ? limit_i : (env_i - rate_i);
    end
  end

endmodule

// File: rtl/envelope_generator.sv
// Single-voice ADSR amplitude envelope, level updates paced by sample_tick.
// Ports:
//   CLK, RESET      - clock, synchronous active-high reset
//   gate            - note-on (level-sensitive); rising edge starts ATTACK, falling edge RELEASE
//   sample_tick     - one-cycle strobe per audio sample; one env update per tick
//   attack_inc, decay_dec, sustain_level, release_dec - rates/level, sampled on each tick
//   env             - current level (registered)
//   active          - high while not idle (registered)
//   env_state       - current state encoding (registered)
// Build option: ENV_RETRIGGER_EN defined makes a gate rise reset env to 0 (hard retrigger);
// otherwise a rise keeps the current level (legato).
module envelope_generator
  import synth_pkg::*;
#(
  parameter int unsigned   W   = ENV_W,
  parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         gate,
  input  logic         sample_tick,
  input  logic [W-1:0] attack_inc,
  input  logic [W-1:0] decay_dec,
  input  logic [W-1:0] sustain_level,
  input  logic [W-1:0] release_dec,
  output logic [W-1:0] env,
  output logic         active,
  output logic [2:0]   env_state
);

  env_state_t   state_q, state_d;
  logic [W-1:0] env_q, env_d;
  logic         gate_q, gate_d;
  logic         active_q, active_d;

  logic         rise, fall;
  logic [W-1:0] step_rate, step_limit, step_env;
  logic         step_up, step_hit;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  // One shared stepper; its operands are muxed by the current state.
  always_comb begin
    step_rate  = '0;
    step_limit = '0;
    step_up    = 1'b0;
    unique case (state_q)
      StAttack: begin
        step_rate  = attack_inc;
        step_limit = MAX;
        step_up    = 1'b1;
      end
      StDecay: begin
        step_rate  = decay_dec;
        step_limit = sustain_level;
      end
      StRelease: begin
        step_rate  = release_dec;
      end
      default: ;
    endcase
  end

  env_sat_step #(
    .W (W)
  ) u_step (
    .env_i   (env_q),
    .rate_i  (step_rate),
    .limit_i (step_limit),
    .up_i    (step_up),
    .env_o   (step_env),
    .hit_o   (step_hit)
  );

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    gate_d  = gate;

    if (rise) begin
      // Gate edges swallow a coincident tick: no level update this cycle.
      state_d = StAttack;
`ifdef ENV_RETRIGGER_EN
      env_d   = '0;
`endif
    end else if (fall && (state_q == StAttack || state_q == StDecay ||
                          state_q == StSustain)) begin
      state_d = StRelease;
    end else if (sample_tick) begin
      unique case (state_q)
        StAttack: begin
          env_d = step_env;
          if (step_hit) state_d = StDecay;
        end
        StDecay: begin
          env_d = step_env;
          if (step_hit) state_d = StSustain;
        end
        StSustain: env_d = sustain_level;
        StRelease: begin
          env_d = step_env;
          if (step_hit) state_d = StIdle;
        end
        default:   env_d = '0;
      endcase
    end

    active_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      env_q    <= '0;
      gate_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      gate_q   <= gate_d;
      active_q <= active_d;
    end
  end

  assign env       = env_q;
  assign active    = active_q;
  assign env_state = state_q;

endmodule

// File: tb/tb_envelope_generator.sv
// Directed, table-driven bench for envelope_generator. Each table row is one clock:
// inputs applied before the edge, outputs compared 1 time unit after it.
module tb_envelope_generator;

  localparam int W = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ATK  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_SUS  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  // Re-gate at 0x8000 during RELEASE: legato keeps the level, retrigger restarts from 0.
`ifdef ENV_RETRIGGER_EN
  localparam logic [15:0] REGATE_ENV = 16'h0000;
  localparam logic [15:0] REGATE_NXT = 16'h4000;
`else
  localparam logic [15:0] REGATE_ENV = 16'h8000;
  localparam logic [15:0] REGATE_NXT = 16'hC000;
`endif

  logic         CLK = 1'b0;
  logic         RESET;
  logic         gate;
  logic         sample_tick;
  logic [W-1:0] attack_inc, decay_dec, sustain_level, release_dec;
  logic [W-1:0] env;
  logic         active;
  logic [2:0]   env_state;

  int checks = 0;
  int failures = 0;

  envelope_generator dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .gate          (gate),
    .sample_tick   (sample_tick),
    .attack_inc    (attack_inc),
    .decay_dec     (decay_dec),
    .sustain_level (sustain_level),
    .release_dec   (release_dec),
    .env           (env),
    .active        (active),
    .env_state     (env_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        gate;
    logic        tick;
    logic [15:0] atk;
    logic [15:0] dec;
    logic [15:0] sus;
    logic [15:0] rel;
    logic [15:0] exp_env;
    logic [2:0]  exp_state;
    logic        exp_active;
  } vec_t;

  vec_t vecs[$];

  // Row with the default rates.
  function automatic vec_t vd(logic rst, logic g, logic t, logic [15:0] e, logic [2:0] s,
                              logic a);
    vec_t v;
    v = '{rst, g, t, 16'h4000, 16'h1000, 16'hC000, 16'h4000, e, s, a};
    return v;
  endfunction

  // Row with explicit rates.
  function automatic vec_t vr(logic g, logic t, logic [15:0] at, logic [15:0] de,
                              logic [15:0] su, logic [15:0] re, logic [15:0] e,
                              logic [2:0] s, logic a);
    vec_t v;
    v = '{1'b0, g, t, at, de, su, re, e, s, a};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e, input logic [2:0] s,
                           input logic a);
    check({tag, ".env"}, {16'h0, env}, {16'h0, e});
    check({tag, ".state"}, {29'h0, env_state}, {29'h0, s});
    check({tag, ".active"}, {31'h0, active}, {31'h0, a});
  endtask

  task automatic cycle(input logic rst, input logic g, input logic t);
    RESET       = rst;
    gate        = g;
    sample_tick = t;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; gate = 1'b0; sample_tick = 1'b0;
    attack_inc = 16'h4000; decay_dec = 16'h1000; sustain_level = 16'hC000;
    release_dec = 16'h4000;

    // Reset held 3 clocks with gate high, then gate-high after reset counts as a rise.
    repeat (3) vecs.push_back(vd(1, 1, 0, 16'h0000, S_IDLE, 0));
    vecs.push_back(vd(0, 1, 0, 16'h0000, S_ATK, 1));
    // Attack
    vecs.push_back(vd(0, 1, 1, 16'h4000, S_ATK, 1));
    vecs.push_back(vd(0, 1, 1, 16'h8000, S_ATK, 1));
    vecs.push_back(vd(0, 1, 1, 16'hC000, S_ATK, 1));
    vecs.push_back(vd(0, 1, 1, 16'hFFFF, S_DEC, 1));
    vecs.push_back(vd(0, 1, 0, 16'hFFFF, S_DEC, 1));   // no tick, no change
    // Decay
    vecs.push_back(vd(0, 1, 1, 16'hEFFF, S_DEC, 1));
    vecs.push_back(vd(0, 1, 1, 16'hDFFF, S_DEC, 1));
    vecs.push_back(vd(0, 1, 1, 16'hCFFF, S_DEC, 1));
    vecs.push_back(vd(0, 1, 1, 16'hC000, S_SUS, 1));
    // Release
    vecs.push_back(vd(0, 0, 0, 16'hC000, S_REL, 1));
    vecs.push_back(vd(0, 0, 1, 16'h8000, S_REL, 1));
    vecs.push_back(vd(0, 0, 1, 16'h4000, S_REL, 1));
    vecs.push_back(vd(0, 0, 1, 16'h0000, S_IDLE, 0));
    // Attack to 0x8000, then fall and re-gate each coinciding with a tick.
    vecs.push_back(vd(0, 1, 0, 16'h0000, S_ATK, 1));
    vecs.push_back(vd(0, 1, 1, 16'h4000, S_ATK, 1));
    vecs.push_back(vd(0, 1, 1, 16'h8000, S_ATK, 1));
    vecs.push_back(vd(0, 0, 1, 16'h8000, S_REL, 1));   // fall wins over tick
    vecs.push_back(vd(0, 1, 1, REGATE_ENV, S_ATK, 1)); // rise wins over tick
    vecs.push_back(vd(0, 1, 1, REGATE_NXT, S_ATK, 1));
    vecs.push_back(vd(0, 0, 0, REGATE_NXT, S_REL, 1));
    vecs.push_back(vr(0, 1, 16'h4000, 16'h1000, 16'hC000, 16'h0000, 16'h0000, S_IDLE, 0));
    // Zero rates: each phase completes in one tick.
    vecs.push_back(vr(1, 0, 16'h0, 16'h0, 16'hC000, 16'h0, 16'h0000, S_ATK, 1));
    vecs.push_back(vr(1, 1, 16'h0, 16'h0, 16'hC000, 16'h0, 16'hFFFF, S_DEC, 1));
    vecs.push_back(vr(1, 1, 16'h0, 16'h0, 16'hC000, 16'h0, 16'hC000, S_SUS, 1));
    vecs.push_back(vr(0, 0, 16'h0, 16'h0, 16'hC000, 16'h0, 16'hC000, S_REL, 1));
    vecs.push_back(vr(0, 1, 16'h0, 16'h0, 16'hC000, 16'h0, 16'h0000, S_IDLE, 0));
    // Sustain tracking of a live level change, then release below rate.
    vecs.push_back(vd(0, 1, 0, 16'h0000, S_ATK, 1));
    vecs.push_back(vd(0, 1, 1, 16'h4000, S_ATK, 1));
    vecs.push_back(vd(0, 1, 1, 16'h8000, S_ATK, 1));
    vecs.push_back(vd(0, 1, 1, 16'hC000, S_ATK, 1));
    vecs.push_back(vd(0, 1, 1, 16'hFFFF, S_DEC, 1));
    vecs.push_back(vd(0, 1, 1, 16'hEFFF, S_DEC, 1));
    vecs.push_back(vd(0, 1, 1, 16'hDFFF, S_DEC, 1));
    vecs.push_back(vd(0, 1, 1, 16'hCFFF, S_DEC, 1));
    vecs.push_back(vd(0, 1, 1, 16'hC000, S_SUS, 1));
    vecs.push_back(vr(1, 0, 16'h4000, 16'h1000, 16'h2000, 16'h3000, 16'hC000, S_SUS, 1));
    vecs.push_back(vr(1, 1, 16'h4000, 16'h1000, 16'h2000, 16'h3000, 16'h2000, S_SUS, 1));
    vecs.push_back(vr(0, 0, 16'h4000, 16'h1000, 16'h2000, 16'h3000, 16'h2000, S_REL, 1));
    vecs.push_back(vr(0, 1, 16'h4000, 16'h1000, 16'h2000, 16'h3000, 16'h0000, S_IDLE, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      attack_inc    = vecs[i].atk;
      decay_dec     = vecs[i].dec;
      sustain_level = vecs[i].sus;
      release_dec   = vecs[i].rel;
      cycle(vecs[i].rst, vecs[i].gate, vecs[i].tick);
      check_all($sformatf("vec%0d", i), vecs[i].exp_env, vecs[i].exp_state,
                vecs[i].exp_active);
    end

    // Reset in mid-attack with gate and tick held high: reset wins, then the
    // still-high gate is a fresh rise that also beats the coincident tick.
    attack_inc = 16'h0100; decay_dec = 16'h1000; sustain_level = 16'hC000;
    release_dec = 16'h4000;
    cycle(0, 1, 0);
    check_all("mid.rise", 16'h0000, S_ATK, 1);
    cycle(0, 1, 1);
    check_all("mid.tick", 16'h0100, S_ATK, 1);
    cycle(1, 1, 1);
    check_all("mid.reset", 16'h0000, S_IDLE, 0);
    cycle(0, 1, 1);
    check_all("mid.rerise", 16'h0000, S_ATK, 1);
    cycle(0, 1, 1);
    check_all("mid.tick2", 16'h0100, S_ATK, 1);

    // Attack saturation with a large increment: 0xF000 + 0xF000 clamps to 0xFFFF.
    attack_inc = 16'hF000;
    cycle(1, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    check_all("sat.first", 16'hF000, S_ATK, 1);
    cycle(0, 1, 1);
    check_all("sat.clamp", 16'hFFFF, S_DEC, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/envelope_generator.md
# envelope_generator

Single-voice ADSR amplitude envelope. It sits directly downstream of the arpeggiator: one instance per key line consumes that line's note-on gate and produces a 16-bit unsigned amplitude for the voice's output multiplier. All level updates are paced by a one-cycle sample strobe, so every envelope time is expressed in samples, not clocks.

## Interface
Parameters:
- `W`, 16, envelope level / rate width
- `MAX`, `{W{1'b1}}`, full-scale level

Ports:
- `CLK` in 1 — system clock
- `RESET` in 1 — synchronous, active-high; clock CLK
- `gate` in 1 — note-on from arpeggiator output line; level-sensitive
- `sample_tick` in 1 — one-cycle strobe, one per audio sample
- `attack_inc` in W — level added per tick in ATTACK
- `decay_dec` in W — level subtracted per tick in DECAY
- `sustain_level` in W — hold level while gate is high
- `release_dec` in W — level subtracted per tick in RELEASE
- `env` out W — current level, registered
- `active` out 1 — high when state ≠ IDLE, registered
- `env_state` out 3 — current state encoding, registered (debug/LED)

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- `gate_q` is a registered copy of `gate`.
  - rise = gate & !gate_q
  - fall = !gate & gate_q
- Events, in priority order, evaluated every clock:
  1. RESET → IDLE, env=0, gate_q=0.
  2. rise (only possible from IDLE or RELEASE) → ATTACK. env keeps its current value. No level update this cycle, even if sample_tick is high.
  3. fall while in ATTACK, DECAY or SUSTAIN → RELEASE. env keeps its current value. No level update this cycle.
  4. sample_tick → per-state update below.
- Per-tick update, all arithmetic in W+1 bits (no wrap):
  - ATTACK: if attack_inc==0 or env+attack_inc ≥ MAX, then env=MAX and go to DECAY; else env+=attack_inc.
  - DECAY: if decay_dec==0 or env ≤ sustain_level+decay_dec, then env=sustain_level and go to SUSTAIN; else env-=decay_dec.
  - SUSTAIN: env=sustain_level. Tracks live changes to sustain_level.
  - RELEASE: if release_dec==0 or env ≤ release_dec, then env=0 and go to IDLE; else env-=release_dec.
  - IDLE: env stays 0.
- A rate of 0 means an instantaneous step on the next tick, never a stall.
- If gate is high in the cycle after RESET deasserts, that counts as a rise (gate_q was cleared).
- Rate and sustain inputs are sampled at each tick and may change at any time. Changing them mid-phase takes effect at the next tick.

## Timing
- Reset values: env=0, active=0, env_state=IDLE.
- gate first high at edge n → env_state=ATTACK and active=1 visible after edge n.
- First level change happens at the first tick strictly after edge n.
- Each tick produces exactly one env update, visible one clock after the tick cycle.
- A state change caused by a tick and the clamped env value appear in the same cycle.
- Back-to-back ticks (every cycle) are legal.

## Configuration
- `ENV_RETRIGGER_EN` defined: a rise forces env=0 in the same cycle it enters ATTACK (hard retrigger, audible restart).
- Not defined: a rise leaves env at its current value (legato; no click when the arpeggiator re-gates a note).

## Structure
- Shared package `synth_pkg`:
  - `env_state_t` enum (logic [2:0]: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4)
  - `ENV_W` = 16
  - `ENV_MAX`
- Sub-module `env_sat_step`: combinational; given env, rate, floor/ceiling and direction, returns the next env and a `hit` flag. Used once per state branch, or shared through a mux.

## Test plan
Unless stated otherwise: attack_inc=0x4000, decay_dec=0x1000, sustain_level=0xC000, release_dec=0x4000.
- Reset: hold RESET for 3 clocks with gate=1 → env=0, active=0, env_state=IDLE. Release RESET → ATTACK one clock later.
- Full ADSR:
  - rise, then 4 ticks → env 0x4000, 0x8000, 0xC000, 0xFFFF; state DECAY.
  - 4 more ticks → 0xEFFF, 0xDFFF, 0xCFFF, 0xC000; state SUSTAIN.
  - drop gate, then 3 ticks → 0x8000, 0x4000, 0x0000; state IDLE; active=0.
- Re-gate during RELEASE at env=0x8000:
  - without the macro: ATTACK, and the next tick gives 0xC000.
  - with `ENV_RETRIGGER_EN`: env=0, and the next tick gives 0x4000.
- Gate edge and sample_tick in the same cycle → state changes, env unchanged that cycle.
- attack_inc=0, decay_dec=0, release_dec=0 → each phase completes in exactly one tick (0 → 0xFFFF → 0xC000, then after gate drops → 0).
- In SUSTAIN, change sustain_level to 0x2000 → env=0x2000 after the next tick. Drop gate with release_dec=0x3000 → next tick gives 0, IDLE.
